// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between NUM_REQ requesters.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.

package rv;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_EQ   = 5'd10,
    ALU_NE   = 5'd11,
    ALU_LT   = 5'd12,
    ALU_GE   = 5'd13,
    ALU_LTU  = 5'd14,
    ALU_GEU  = 5'd15
  } RV32_ALU_OPCODE;

endpackage

module alu
  import rv::*;
(
  input  logic [31:0]    op1,
  input  logic [31:0]    op2,
  input  RV32_ALU_OPCODE opcode,
  output logic [31:0]    result
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = op2[4:0];
  assign lt_s  = $signed(op1) < $signed(op2);
  assign lt_u  = op1 < op2;

  always_comb begin
    result = '0;
    unique case (opcode)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_SLL:  result = op1 << shamt;
      ALU_SLT:  result = {31'd0, lt_s};
      ALU_SLTU: result = {31'd0, lt_u};
      ALU_XOR:  result = op1 ^ op2;
      ALU_SRL:  result = op1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(op1) >>> shamt);
      ALU_OR:   result = op1 | op2;
      ALU_AND:  result = op1 & op2;
      ALU_EQ:   result = {31'd0, op1 == op2};
      ALU_NE:   result = {31'd0, op1 != op2};
      ALU_LT:   result = {31'd0, lt_s};
      ALU_GE:   result = {31'd0, !lt_s};
      ALU_LTU:  result = {31'd0, lt_u};
      ALU_GEU:  result = {31'd0, !lt_u};
      default:  result = 'x;
    endcase
  end

endmodule

module alu_arbiter
  import rv::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic           [NUM_REQ-1:0]    req_valid,
  output logic           [NUM_REQ-1:0]    req_ready,
  input  logic           [NUM_REQ-1:0][31:0] req_op1,
  input  logic           [NUM_REQ-1:0][31:0] req_op2,
  input  RV32_ALU_OPCODE [NUM_REQ-1:0]    req_opcode,
  output logic           [NUM_REQ-1:0]    resp_valid,
  input  logic           [NUM_REQ-1:0]    resp_ready,
  output logic           [31:0]           resp_result
);

  logic           s1_valid;
  logic [IDW-1:0] s1_owner;
  logic [31:0]    s1_op1;
  logic [31:0]    s1_op2;
  RV32_ALU_OPCODE s1_opcode;

  logic           s2_valid;
  logic [IDW-1:0] s2_owner;
  logic [31:0]    s2_result;

  logic [31:0]    alu_res;
  logic           resp_fire;
  logic           s2_free;
  logic           s1_adv;
  logic           s1_free;
  logic           found;
  logic [IDW-1:0] gnt_id;
  logic           accept;

  alu u_alu (
    .op1    (s1_op1),
    .op2    (s1_op2),
    .opcode (s1_opcode),
    .result (alu_res)
  );

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = s2_valid && (s2_owner == IDW'(i));
    end
  end

  assign resp_result = s2_result;
  assign resp_fire   = |(resp_valid & resp_ready);
  assign s2_free     = !s2_valid || resp_fire;
  assign s1_adv      = s1_valid && s2_free;
  assign s1_free     = !s1_valid || s1_adv;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] last;

  // Search begins just after the most recent winner and wraps.
  always_comb begin
    logic [IDW-1:0] idx;
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IDW'(NUM_REQ - 1);
    end else if (accept) begin
      last <= gnt_id;
    end
  end
`else
  // Walk downwards so the lowest valid index is the last one written.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found  = 1'b1;
        gnt_id = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (s1_free && found && !rst) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  assign accept = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_owner  <= '0;
      s1_op1    <= '0;
      s1_op2    <= '0;
      s1_opcode <= ALU_ADD;
      s2_valid  <= 1'b0;
      s2_owner  <= '0;
      s2_result <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid  <= 1'b1;
        s2_owner  <= s1_owner;
        s2_result <= alu_res;
      end else if (resp_fire) begin
        s2_valid  <= 1'b0;
      end
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_owner  <= gnt_id;
        s1_op1    <= req_op1[gnt_id];
        s1_op2    <= req_op2[gnt_id];
        s1_opcode <= req_opcode[gnt_id];
      end else if (s1_adv) begin
        s1_valid  <= 1'b0;
      end
    end
  end

  // Encodings 16..31 are not operations; a requester sending one is broken.
  a_legal_op: assert property (
    @(posedge clk) disable iff (rst)
    s1_valid |-> !s1_opcode[4]
  );

  a_one_grant: assert property (
    @(posedge clk) disable iff (rst)
    $onehot0(req_ready)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (2 requesters).
// Contention expectations follow ALU_ARB_ROUND_ROBIN_EN.

module tb_alu_arbiter;
  import rv::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_op1;
  logic [1:0][31:0]      req_op2;
  RV32_ALU_OPCODE [1:0]  req_opcode;
  logic [1:0]            resp_valid;
  logic [1:0]            resp_ready;
  logic [31:0]           resp_result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_opcode  (req_opcode),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input int r, input RV32_ALU_OPCODE op,
                       input logic [31:0] a, input logic [31:0] b);
    req_opcode[r] = op;
    req_op1[r]    = a;
    req_op2[r]    = b;
  endtask

  RV32_ALU_OPCODE s_op[3] = '{ALU_SUB, ALU_SRA, ALU_SLTU};
  logic [31:0] s_a[3]   = '{32'd10, 32'h8000_0000, 32'd1};
  logic [31:0] s_b[3]   = '{32'd3, 32'd4, 32'd2};
  logic [31:0] s_exp[3] = '{32'd7, 32'hF800_0000, 32'd1};

  logic [31:0] x_a[4]   = '{32'hFFFF_0000, 32'h1234_5678,
                            32'hAAAA_AAAA, 32'h0000_000F};
  logic [31:0] x_b[4]   = '{32'h00FF_00FF, 32'hFFFF_FFFF,
                            32'h5555_5555, 32'h0000_00F0};
  logic [31:0] x_exp[4] = '{32'hFF00_00FF, 32'hEDCB_A987,
                            32'hFFFF_FFFF, 32'h0000_00FF};
  logic        x_rr[10]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  logic        x_rdy[10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
  logic        x_rv[10]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  int          x_idx[10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};

  initial begin
    int          qo[$];
    logic [31:0] qr[$];
    int          k[2];
    int          g;
    int          n;

    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    drive(0, ALU_ADD, '0, '0);
    drive(1, ALU_ADD, '0, '0);
    cyc();
    cyc();
    settle();
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_rr", 32'(req_ready), 32'd0);
    chk("rst_res", resp_result, 32'd0);
    rst = 1'b0;

    // single op
    resp_ready = 2'b11;
    req_valid  = 2'b01;
    drive(0, ALU_ADD, 32'd5, 32'd7);
    settle();
    chk("one_rdy", 32'(req_ready), 32'd1);
    cyc();
    req_valid = '0;
    settle();
    chk("one_c1_rv", 32'(resp_valid), 32'd0);
    cyc();
    settle();
    chk("one_c2_rv", 32'(resp_valid), 32'd1);
    chk("one_c2_res", resp_result, 32'd12);
    cyc();
    settle();
    chk("one_c3_rv", 32'(resp_valid), 32'd0);

    // back-to-back stream on requester 1
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        req_valid = 2'b10;
        drive(1, s_op[c], s_a[c], s_b[c]);
      end else begin
        req_valid = '0;
      end
      settle();
      if (c < 3) chk($sformatf("strm_rdy%0d", c), 32'(req_ready), 32'd2);
      if (c >= 2) begin
        chk($sformatf("strm_rv%0d", c), 32'(resp_valid), 32'd2);
        chk($sformatf("strm_res%0d", c), resp_result, s_exp[c-2]);
      end
      cyc();
    end
    settle();
    chk("strm_end_rv", 32'(resp_valid), 32'd0);

    // contention: both requesters valid for six cycles
    k[0] = 0;
    k[1] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 2; r++) begin
        drive(r, ALU_ADD, 32'(k[r] * 16 + r), 32'h100 << r);
      end
      req_valid = (c < 6) ? 2'b11 : 2'b00;
      settle();
      if (c < 6) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
        g = c % 2;
`else
        g = 0;
`endif
        chk($sformatf("ctn_rdy%0d", c), 32'(req_ready), 32'(1 << g));
        qo.push_back(g);
        qr.push_back(req_op1[g] + req_op2[g]);
        k[g]++;
      end
      if (c >= 2) begin
        g = qo.pop_front();
        chk($sformatf("ctn_rv%0d", c), 32'(resp_valid), 32'(1 << g));
        chk($sformatf("ctn_res%0d", c), resp_result, qr.pop_front());
      end
      cyc();
    end

    // back-pressure on requester 0
    n = 0;
    for (int c = 0; c < 10; c++) begin
      resp_ready = {1'b1, x_rr[c]};
      if (n < 4) begin
        req_valid = 2'b01;
        drive(0, ALU_XOR, x_a[n], x_b[n]);
      end else begin
        req_valid = '0;
      end
      settle();
      chk($sformatf("bp_rdy%0d", c), 32'(req_ready), 32'(x_rdy[c]));
      chk($sformatf("bp_rv%0d", c), 32'(resp_valid), 32'(x_rv[c]));
      if (x_rv[c]) begin
        chk($sformatf("bp_res%0d", c), resp_result, x_exp[x_idx[c]]);
      end
      if (req_ready[0]) n++;
      cyc();
    end
    chk("bp_accepts", 32'(n), 32'd4);

    // reset with S1 and S2 both occupied
    resp_ready = '0;
    req_valid  = 2'b01;
    drive(0, ALU_ADD, 32'd1, 32'd1);
    settle();
    chk("mr_rdy0", 32'(req_ready), 32'd1);
    cyc();
    drive(0, ALU_AND, 32'hF, 32'h3);
    settle();
    chk("mr_rdy1", 32'(req_ready), 32'd1);
    cyc();
    settle();
    chk("mr_full_rv", 32'(resp_valid), 32'd1);
    chk("mr_full_rdy", 32'(req_ready), 32'd0);
    rst       = 1'b1;
    req_valid = '0;
    cyc();
    rst        = 1'b0;
    resp_ready = 2'b11;
    req_valid  = 2'b01;
    drive(0, ALU_EQ, 32'd3, 32'd3);
    settle();
    chk("mr_post_rv", 32'(resp_valid), 32'd0);
    chk("mr_post_res", resp_result, 32'd0);
    chk("mr_post_rdy", 32'(req_ready), 32'd1);
    cyc();
    req_valid = '0;
    settle();
    chk("mr_eq_c1_rv", 32'(resp_valid), 32'd0);
    cyc();
    settle();
    chk("mr_eq_rv", 32'(resp_valid), 32'd1);
    chk("mr_eq_res", resp_result, 32'd1);
    cyc();
    settle();
    chk("mr_end_rv", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
